// File: rtl/mem_arbiter.sv
// mem_arbiter: three-requester round-robin burst arbiter for a single
// beat-oriented memory port. Requesters 0/1 read, requester 2 writes.
// Each beat is one command strobe followed by a wait for mem_valid.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 512,
   parameter int unsigned LEN_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            req,
   input  logic [3*ADDR_W-1:0]   req_addr,
   input  logic [3*LEN_W-1:0]    req_len,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W-1:0]     mem_read_data,
   input  logic                  mem_valid,
   output logic [2:0]            grant,
   output logic [2:0]            done,
   output logic [DATA_W-1:0]     rd_data,
   output logic [2:0]            rd_valid,
   output logic                  wr_ack,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_write_data,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  busy
);

   // Address advance per beat; wraps silently at 2^ADDR_W.
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t               state_q, state_n;
   logic [1:0]           owner_q, owner_n;
   logic [1:0]           ptr_q, ptr_n;
   logic [LEN_W-1:0]     len_q, len_n;
   logic [LEN_W-1:0]     beat_q, beat_n;

   logic [2:0]           grant_n, done_n, rd_valid_n;
   logic                 wr_ack_n, mem_read_n, mem_write_n, busy_n;
   logic [ADDR_W-1:0]    addr_n;
   logic [DATA_W-1:0]    wdata_n, rdata_n;

   logic                 win_found;
   logic [1:0]           win_idx;
   logic [1:0]           cand;
   logic [ADDR_W-1:0]    sel_addr;
   logic [LEN_W-1:0]     sel_len;

   // Round-robin winner: scan requesters starting one past the last owner
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int unsigned k = 1; k <= 3; k++) begin
         cand = 2'((32'(ptr_q) + k) % 3);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Start address and length of the winning requester
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      unique case (win_idx)
         2'd0: begin
            sel_addr = req_addr[0*ADDR_W +: ADDR_W];
            sel_len  = req_len[0*LEN_W +: LEN_W];
         end
         2'd1: begin
            sel_addr = req_addr[1*ADDR_W +: ADDR_W];
            sel_len  = req_len[1*LEN_W +: LEN_W];
         end
         2'd2: begin
            sel_addr = req_addr[2*ADDR_W +: ADDR_W];
            sel_len  = req_len[2*LEN_W +: LEN_W];
         end
         default: begin
            sel_addr = '0;
            sel_len  = '0;
         end
      endcase
   end

   // Next-state and next-output logic; command strobes are computed on the
   // transition into ISSUE so the registered strobe lines up with ISSUE.
   always_comb begin
      state_n     = state_q;
      owner_n     = owner_q;
      ptr_n       = ptr_q;
      len_n       = len_q;
      beat_n      = beat_q;
      grant_n     = grant;
      addr_n      = mem_addr;
      wdata_n     = mem_write_data;
      rdata_n     = rd_data;
      done_n      = '0;
      rd_valid_n  = '0;
      wr_ack_n    = 1'b0;
      mem_read_n  = 1'b0;
      mem_write_n = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_n     = ISSUE;
               owner_n     = win_idx;
               len_n       = sel_len;
               beat_n      = '0;
               addr_n      = sel_addr;
               wdata_n     = wr_data;
               grant_n     = 3'b001 << win_idx;
               mem_read_n  = (win_idx != 2'd2);
               mem_write_n = (win_idx == 2'd2);
            end
         end
         ISSUE: begin
            state_n = WAIT;
         end
         WAIT: begin
            if (mem_valid) begin
               if (owner_q == 2'd2) begin
                  wr_ack_n = 1'b1;
               end else begin
                  rd_valid_n = 3'b001 << owner_q;
                  rdata_n    = mem_read_data;
               end
               if (beat_q == len_q) begin
                  state_n = DONE;
                  done_n  = 3'b001 << owner_q;
               end else begin
                  state_n     = ISSUE;
                  beat_n      = beat_q + 1'b1;
                  addr_n      = mem_addr + STEP;
                  wdata_n     = wr_data;
                  mem_read_n  = (owner_q != 2'd2);
                  mem_write_n = (owner_q == 2'd2);
               end
            end
         end
         DONE: begin
            state_n = IDLE;
            grant_n = '0;
            ptr_n   = owner_q;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   // State and registered outputs; reset abandons any burst in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         owner_q        <= 2'd0;
         ptr_q          <= 2'd2;
         len_q          <= '0;
         beat_q         <= '0;
         grant          <= '0;
         done           <= '0;
         rd_valid       <= '0;
         wr_ack         <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         busy           <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         rd_data        <= '0;
      end else begin
         state_q        <= state_n;
         owner_q        <= owner_n;
         ptr_q          <= ptr_n;
         len_q          <= len_n;
         beat_q         <= beat_n;
         grant          <= grant_n;
         done           <= done_n;
         rd_valid       <= rd_valid_n;
         wr_ack         <= wr_ack_n;
         mem_read       <= mem_read_n;
         mem_write      <= mem_write_n;
         busy           <= busy_n;
         mem_addr       <= addr_n;
         mem_write_data <= wdata_n;
         rd_data        <= rdata_n;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter. Stimulus pushes
// the expected output events; a monitor pops and compares them as they occur.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 512;
   localparam int unsigned LEN_W  = 8;

   localparam int K_GRANT = 0;
   localparam int K_RDCMD = 1;
   localparam int K_WRCMD = 2;
   localparam int K_RDV   = 3;
   localparam int K_WACK  = 4;
   localparam int K_DONE  = 5;

   typedef struct {
      int                kind;
      logic [2:0]        vec;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } ev_t;

   logic                  clk;
   logic                  rst_n;
   logic [2:0]            req;
   logic [3*ADDR_W-1:0]   req_addr;
   logic [3*LEN_W-1:0]    req_len;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W-1:0]     mem_read_data;
   logic                  mem_valid;
   logic [2:0]            grant;
   logic [2:0]            done;
   logic [DATA_W-1:0]     rd_data;
   logic [2:0]            rd_valid;
   logic                  wr_ack;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_write_data;
   logic                  mem_read;
   logic                  mem_write;
   logic                  busy;

   logic                  resp_en;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_data;
   logic                  man_valid;
   logic [DATA_W-1:0]     man_data;

   int n_cmp = 0;
   int n_err = 0;
   ev_t exp_q[$];

   localparam logic [DATA_W-1:0] W1  = {16{32'hC0DE_0001}};
   localparam logic [DATA_W-1:0] W2  = {8{64'h0123_4567_89AB_CDEF}};
   localparam logic [DATA_W-1:0] BAD = {16{32'hBAD0_BAD0}};

   assign mem_valid     = resp_valid | man_valid;
   assign mem_read_data = man_valid ? man_data : resp_data;

   mem_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req),
      .req_addr       (req_addr),
      .req_len        (req_len),
      .wr_data        (wr_data),
      .mem_read_data  (mem_read_data),
      .mem_valid      (mem_valid),
      .grant          (grant),
      .done           (done),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .wr_ack         (wr_ack),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory read data is a fixed function of the beat address.
   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
      return {16{a ^ 32'h5A5A_F00F}};
   endfunction

   function automatic string kname(input int k);
      case (k)
         K_GRANT: return "grant";
         K_RDCMD: return "rd_cmd";
         K_WRCMD: return "wr_cmd";
         K_RDV:   return "rd_valid";
         K_WACK:  return "wr_ack";
         default: return "done";
      endcase
   endfunction

   task automatic push(input int k, input logic [2:0] v, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
      ev_t e;
      e.kind = k; e.vec = v; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int k, input logic [2:0] v, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_%s: got vec=%b addr=%h data=%h required no event",
                  kname(k), v, a, d[63:0]);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.vec !== v || e.addr !== a || e.data !== d) begin
            n_err++;
            $display("FAIL ev_%s: got %s vec=%b addr=%h data=%h required %s vec=%b addr=%h data=%h",
                     kname(e.kind), kname(k), v, a, d[63:0], kname(e.kind), e.vec, e.addr,
                     e.data[63:0]);
         end
      end
   endtask

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] req_v);
      n_cmp++;
      if (act !== req_v) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act[63:0], req_v[63:0]);
      end
   endtask

   task automatic check_zero(input string name);
      check({name, "_ctrl"}, DATA_W'({grant, done, rd_valid, wr_ack, mem_read, mem_write, busy}), '0);
      check({name, "_addr"}, DATA_W'(mem_addr), '0);
      check({name, "_rd_data"}, rd_data, '0);
      check({name, "_wr_data"}, mem_write_data, '0);
   endtask

   task automatic set_slot(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_len[i*LEN_W +: LEN_W]    = l;
   endtask

   // Raise req until the grant appears, then drop it and scramble the
   // request fields so any late sampling shows up as a wrong burst.
   task automatic run_req(input logic [2:0] r);
      int t;
      t = 0;
      @(negedge clk);
      req = r;
      do begin
         @(negedge clk);
         t++;
      end while (grant == 3'b000 && t < 20);
      if (grant == 3'b000) begin
         n_cmp++; n_err++;
         $display("FAIL wait_grant: got grant=%b required nonzero", grant);
      end
      req      = '0;
      req_addr = {3{32'hDEAD_BEEF}};
      req_len  = {3{8'h07}};
   endtask

   task automatic wait_dones(input int n);
      int seen;
      int t;
      seen = 0;
      t = 0;
      while (seen < n && t < 400) begin
         @(negedge clk);
         t++;
         if (done != 3'b000) seen++;
      end
      if (seen < n) begin
         n_cmp++; n_err++;
         $display("FAIL wait_dones: got %0d required %0d", seen, n);
      end
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0 || busy) begin
         n_err++;
         $display("FAIL %s_drain: got pending=%0d busy=%b required pending=0 busy=0",
                  name, exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   // Memory responder: completes each command two cycles after it appears.
   initial begin
      logic              pend;
      logic [ADDR_W-1:0] pa;
      pend       = 1'b0;
      pa         = '0;
      resp_valid = 1'b0;
      resp_data  = '0;
      forever begin
         @(negedge clk);
         resp_valid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            resp_valid = 1'b1;
            resp_data  = pat(pa);
            pend       = 1'b0;
         end else if (resp_en && (mem_read || mem_write)) begin
            pend = 1'b1;
            pa   = mem_addr;
         end
      end
   end

   // Monitor: turns DUT output activity into events and scores them.
   initial begin
      logic [2:0] prev_grant;
      prev_grant = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (grant != 3'b000 && grant != prev_grant) observe(K_GRANT, grant, '0, '0);
            if (mem_read)  observe(K_RDCMD, grant, mem_addr, '0);
            if (mem_write) observe(K_WRCMD, grant, mem_addr, mem_write_data);
            if (rd_valid != 3'b000) observe(K_RDV, rd_valid, '0, rd_data);
            if (wr_ack)    observe(K_WACK, 3'b100, '0, '0);
            if (done != 3'b000) observe(K_DONE, done, '0, '0);
            if ((mem_read && mem_write) || !$onehot0(grant)) begin
               n_cmp++; n_err++;
               $display("FAIL exclusivity: got grant=%b rd=%b wr=%b required onehot0 and not both",
                        grant, mem_read, mem_write);
            end
         end
         prev_grant = grant;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      req_addr  = '0;
      req_len   = '0;
      wr_data   = '0;
      resp_en   = 1'b1;
      man_valid = 1'b0;
      man_data  = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // Contention: all three held, expect 0,1,2,0 with done between
      set_slot(0, 32'h0000_0100, 8'd0);
      set_slot(1, 32'h0000_0200, 8'd0);
      set_slot(2, 32'h0000_0300, 8'd0);
      wr_data = W1;
      push(K_GRANT, 3'b001, '0, '0);
      push(K_RDCMD, 3'b001, 32'h0000_0100, '0);
      push(K_RDV,   3'b001, '0, pat(32'h0000_0100));
      push(K_DONE,  3'b001, '0, '0);
      push(K_GRANT, 3'b010, '0, '0);
      push(K_RDCMD, 3'b010, 32'h0000_0200, '0);
      push(K_RDV,   3'b010, '0, pat(32'h0000_0200));
      push(K_DONE,  3'b010, '0, '0);
      push(K_GRANT, 3'b100, '0, '0);
      push(K_WRCMD, 3'b100, 32'h0000_0300, W1);
      push(K_WACK,  3'b100, '0, '0);
      push(K_DONE,  3'b100, '0, '0);
      push(K_GRANT, 3'b001, '0, '0);
      push(K_RDCMD, 3'b001, 32'h0000_0100, '0);
      push(K_RDV,   3'b001, '0, pat(32'h0000_0100));
      push(K_DONE,  3'b001, '0, '0);
      @(negedge clk);
      req = 3'b111;
      wait_dones(4);
      req = '0;
      drain("contention");

      // Single three-beat read from requester 0
      set_slot(0, 32'h0000_1000, 8'd2);
      push(K_GRANT, 3'b001, '0, '0);
      push(K_RDCMD, 3'b001, 32'h0000_1000, '0);
      push(K_RDCMD, 3'b001, 32'h0000_1040, '0);
      push(K_RDV,   3'b001, '0, pat(32'h0000_1000));
      push(K_RDCMD, 3'b001, 32'h0000_1080, '0);
      push(K_RDV,   3'b001, '0, pat(32'h0000_1040));
      push(K_RDV,   3'b001, '0, pat(32'h0000_1080));
      push(K_DONE,  3'b001, '0, '0);
      run_req(3'b001);
      drain("single_read");

      // Two-beat write from requester 2
      set_slot(2, 32'h0000_2000, 8'd1);
      wr_data = W2;
      push(K_GRANT, 3'b100, '0, '0);
      push(K_WRCMD, 3'b100, 32'h0000_2000, W2);
      push(K_WRCMD, 3'b100, 32'h0000_2040, W2);
      push(K_WACK,  3'b100, '0, '0);
      push(K_WACK,  3'b100, '0, '0);
      push(K_DONE,  3'b100, '0, '0);
      run_req(3'b100);
      drain("write_burst");

      // Address wrap at the top of the address space
      set_slot(1, 32'hFFFF_FFC0, 8'd1);
      push(K_GRANT, 3'b010, '0, '0);
      push(K_RDCMD, 3'b010, 32'hFFFF_FFC0, '0);
      push(K_RDCMD, 3'b010, 32'h0000_0000, '0);
      push(K_RDV,   3'b010, '0, pat(32'hFFFF_FFC0));
      push(K_RDV,   3'b010, '0, pat(32'h0000_0000));
      push(K_DONE,  3'b010, '0, '0);
      run_req(3'b010);
      drain("wrap");

      // Spurious mem_valid in IDLE and ISSUE must be ignored
      resp_en = 1'b0;
      @(negedge clk);
      man_valid = 1'b1;
      man_data  = BAD;
      repeat (3) @(negedge clk);
      man_valid = 1'b0;
      @(negedge clk);
      check("spurious_idle_busy", DATA_W'(busy), '0);
      set_slot(0, 32'h0000_3000, 8'd0);
      push(K_GRANT, 3'b001, '0, '0);
      push(K_RDCMD, 3'b001, 32'h0000_3000, '0);
      push(K_RDV,   3'b001, '0, pat(32'h0000_3000));
      push(K_DONE,  3'b001, '0, '0);
      run_req(3'b001);
      man_valid = 1'b1;
      man_data  = BAD;
      @(negedge clk);
      man_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("spurious_issue_busy", DATA_W'(busy), DATA_W'(1'b1));
      man_valid = 1'b1;
      man_data  = pat(32'h0000_3000);
      @(negedge clk);
      man_valid = 1'b0;
      drain("spurious");

      // Reset during the wait of the second beat of a four-beat read
      set_slot(0, 32'h0000_4000, 8'd3);
      push(K_GRANT, 3'b001, '0, '0);
      push(K_RDCMD, 3'b001, 32'h0000_4000, '0);
      push(K_RDCMD, 3'b001, 32'h0000_4040, '0);
      push(K_RDV,   3'b001, '0, pat(32'h0000_4000));
      run_req(3'b001);
      @(negedge clk);
      man_valid = 1'b1;
      man_data  = pat(32'h0000_4000);
      @(negedge clk);
      man_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("reset_mid");
      check("reset_mid_pending", DATA_W'(exp_q.size()), '0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      resp_en = 1'b1;
      set_slot(1, 32'h0000_5000, 8'd0);
      push(K_GRANT, 3'b010, '0, '0);
      push(K_RDCMD, 3'b010, 32'h0000_5000, '0);
      push(K_RDV,   3'b010, '0, pat(32'h0000_5000));
      push(K_DONE,  3'b010, '0, '0);
      run_req(3'b010);
      drain("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 512, memory data width in bits (one beat).
REQ-003 Parameter LEN_W, default 8, burst-length field width (value = beats - 1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  3  burst request per requester: [0] decompressor read, [1] weight read, [2] compressor write.
REQ-007 req_addr  input  3*ADDR_W  start byte address per requester, slice i = requester i.
REQ-008 req_len  input  3*LEN_W  beats-1 per requester.
REQ-009 wr_data  input  DATA_W  write beat from requester 2.
REQ-010 mem_read_data  input  DATA_W  memory read data, valid with mem_valid.
REQ-011 mem_valid  input  1  memory completion of the current beat (read data present or write accepted).
REQ-012 grant  output  3  one-hot owner of the memory port, 0 when idle.
REQ-013 done  output  3  one-cycle pulse to owner on burst completion.
REQ-014 rd_data  output  DATA_W  registered read beat.
REQ-015 rd_valid  output  3  one-hot pulse, rd_data valid for that requester.
REQ-016 wr_ack  output  1  pulse, current wr_data beat consumed; requester 2 presents next beat.
REQ-017 mem_addr  output  ADDR_W  beat address.
REQ-018 mem_write_data  output  DATA_W  write beat.
REQ-019 mem_read, mem_write  output  1 each  one-cycle beat command strobes.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered (Moore).
REQ-022 IDLE: on any req bit, select winner round-robin starting one past last granted; latch address, length, owner; set grant; go ISSUE next cycle.
REQ-023 ISSUE: assert mem_read (owner 0/1) or mem_write (owner 2) for exactly one cycle with mem_addr = current beat address and mem_write_data = wr_data; go WAIT.
REQ-024 WAIT: hold commands low; on mem_valid, for reads register mem_read_data to rd_data and pulse owner's rd_valid the next cycle; for writes pulse wr_ack the next cycle.
REQ-025 On mem_valid in WAIT: if beat count == latched length go DONE, else increment beat count, add DATA_W/8 to address (modulo 2^ADDR_W, wrap silently), go ISSUE.
REQ-026 DONE: pulse done[owner] one cycle, clear grant, update round-robin pointer to owner, return IDLE; a new grant cannot occur earlier than the cycle after DONE.
REQ-027 Latency: req seen in IDLE at edge N -> grant and mem_command visible cycle N+1; mem_valid at edge M -> rd_valid/wr_ack at cycle M+1.
REQ-028 Requests are sampled only in IDLE; deasserting req mid-burst does not abort the burst; req_addr/req_len changes after grant are ignored.
REQ-029 mem_valid outside WAIT is ignored.
REQ-030 Round-robin pointer after reset = 2, giving priority order 0,1,2 on first arbitration.
REQ-031 At most one of mem_read, mem_write high in any cycle; at most one grant bit high.

Reset
REQ-032 rst_n low asynchronously forces IDLE, clears grant, done, rd_valid, wr_ack, mem_read, mem_write, busy, mem_addr, rd_data, mem_write_data, beat count to 0 and pointer to 2, including mid-burst (burst abandoned, no done pulse).

Verification
REQ-033 Single read: req=001, addr 0x1000, len 2, mem_valid 2 cycles after each command -> mem_addr 0x1000/0x1040/0x1080, three rd_valid[0] pulses, done=001 once.
REQ-034 Contention: req=111 held from reset -> grant order 001, 010, 100, 001; each done before next grant.
REQ-035 Write burst: owner 2, len 1 -> two mem_write pulses, each with mem_write_data equal to wr_data, wr_ack after each mem_valid, done=100.
REQ-036 Wrap: addr 0xFFFFFFC0, len 1 -> second beat mem_addr 0x00000000.
REQ-037 Reset mid-burst: rst_n low in WAIT of beat 1 of 4 -> all outputs 0 immediately, no done; after release req=010 granted first.
REQ-038 Spurious mem_valid in IDLE and ISSUE -> no rd_valid, no state change.
